pipeline_hazard_ctrl: RTL
=========================

// Module: pipeline_hazard_ctrl
// PURPOSE
//  Hazard and recovery sequencer for the 5-stage pipelined core. Drives the write/flush/bubble controls
//  of the PC, IF/ID and ID/EX registers. Handles load-use stalls, branch-misprediction squashes (prediction
//  bit carried into EX vs. actual outcome) and data-memory wait freezes. Keeps saturating performance counters.
// PARAMETERS
//  FLUSH_CYCLES       1   extra squash cycles after the redirect cycle (0..15; 0 = redirect cycle only)
//  LOAD_STALL_CYCLES  1   total bubbles inserted per load-use hazard (1..15)
//  CNT_W              32  width of each performance counter
// PORTS
//  clk             in   1      rising-edge clock
//  reset           in   1      synchronous, active-high reset
//  id_rs1          in   5      rs1 of instruction in ID
//  id_rs2          in   5      rs2 of instruction in ID
//  id_uses_rs2     in   1      ID instruction reads rs2
//  ex_rd           in   5      rd of instruction in EX
//  ex_MemRead      in   1      EX instruction is a load
//  ex_Branch       in   1      EX instruction is a conditional branch
//  ex_prediction   in   1      predicted direction carried with EX branch (1 = taken)
//  ex_taken        in   1      resolved direction of EX branch
//  mem_busy        in   1      data memory not ready; whole pipeline must hold
//  pc_write        out  1      PC may update
//  pc_redirect     out  1      PC mux selects corrected target/fall-through
//  ifid_write      out  1      IF/ID may load
//  ifid_flush      out  1      IF/ID loads a NOP
//  idex_bubble     out  1      ID/EX control fields forced to 0
//  stage_hold      out  1      freeze all pipeline registers (= mem_busy when not in reset)
//  state           out  2      RUN=00, LOAD_STALL=01, FLUSH=10
//  branch_cnt      out  CNT_W  resolved branches
//  mispredict_cnt  out  CNT_W  mispredicted branches
//  stall_cnt       out  CNT_W  cycles with pc_write==0
// BEHAVIOUR
//  - Registered: state, 4-bit down-counter rem, the three counters. Control outputs are combinational from
//    state, rem and current inputs, so detection acts in the same cycle.
//  - reset high (sampled at clk): next state=RUN, rem=0, counters=0.
//    While reset is high: pc_write=0, ifid_write=0, ifid_flush=1, idex_bubble=1, pc_redirect=0, stage_hold=0.
//  - Defaults: pc_write=1, ifid_write=1, all other controls 0.
//  - Decoded conditions:
//    mp  = ex_Branch & (ex_prediction != ex_taken)
//    lu  = ex_MemRead & ex_rd!=0 & (ex_rd==id_rs1 | (id_uses_rs2 & ex_rd==id_rs2))
//  - Priority: mem_busy > mp > lu > state sequencing.
//  - mem_busy=1 (any state): stage_hold=1, pc_write=0, ifid_write=0, no flush/bubble; state and rem hold;
//    branch/mispredict counters do not count.
//  - mp (any state, not busy): pc_redirect=1, pc_write=1, ifid_flush=1, idex_bubble=1.
//    Next: FLUSH with rem=FLUSH_CYCLES if FLUSH_CYCLES>0, else RUN. A pending load stall is abandoned.
//  - FLUSH (no mp): pc_write=1, ifid_flush=1, idex_bubble=1. rem--, and go to RUN when rem==1.
//  - RUN, lu (no mp): pc_write=0, ifid_write=0, idex_bubble=1.
//    Next: LOAD_STALL with rem=LOAD_STALL_CYCLES-1 if LOAD_STALL_CYCLES>1, else RUN.
//  - LOAD_STALL (no mp): same outputs as lu. rem--, and go to RUN when rem==1. lu is not re-evaluated until RUN.
//  - Counters (not in reset) saturate at all-ones, never wrap.
//    branch_cnt += ex_Branch & !mem_busy; mispredict_cnt += mp & !mem_busy; stall_cnt += !pc_write.
//  - Reset mid-FLUSH/LOAD_STALL: returns to RUN next cycle; no residual squash.
// TESTING
//  1 Load-use: ex_MemRead=1, ex_rd=5, id_rs1=5 in RUN, defaults -> one cycle pc_write=0,ifid_write=0,
//    idex_bubble=1; then RUN; stall_cnt=1.
//  2 x0 load: ex_rd=0, id_rs1=0, ex_MemRead=1 -> no stall; id_uses_rs2=0 with rs2 match -> no stall.
//  3 Mispredict: ex_Branch=1, pred=1, taken=0 -> redirect+flush+bubble in cycle N; FLUSH in N+1
//    (flush=1, redirect=0); RUN in N+2; mispredict_cnt=1, branch_cnt=1.
//  4 mem_busy=1 for 3 cycles during FLUSH -> stage_hold=1, state/rem frozen, stall_cnt+=3;
//    the flush cycle completes after release.
//  5 LOAD_STALL_CYCLES=3: hazard with mp asserted in 2nd stall cycle -> redirect that cycle,
//    FLUSH next, then RUN.
//  6 CNT_W=4: 20 resolved branches -> branch_cnt saturates at 15; reset mid-LOAD_STALL -> RUN, counters=0.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and recovery sequencer for the 5-stage pipeline.
// Resolves load-use stalls, branch-misprediction squashes and data-memory
// wait freezes into write/flush/bubble controls for PC, IF/ID and ID/EX.
// Control outputs are combinational from the registered state and the
// current hazard inputs, so a hazard takes effect in the cycle it is seen.
module pipeline_hazard_ctrl #(
    parameter int unsigned FLUSH_CYCLES      = 1,
    parameter int unsigned LOAD_STALL_CYCLES = 1,
    parameter int unsigned CNT_W             = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_MemRead,
    input  logic             ex_Branch,
    input  logic             ex_prediction,
    input  logic             ex_taken,
    input  logic             mem_busy,
    output logic             pc_write,
    output logic             pc_redirect,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             stage_hold,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] mispredict_cnt,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        ST_RUN        = 2'b00,
        ST_LOAD_STALL = 2'b01,
        ST_FLUSH      = 2'b10
    } state_t;

    localparam bit             HAS_FLUSH   = (FLUSH_CYCLES != 0);
    localparam bit             HAS_LS_TAIL = (LOAD_STALL_CYCLES > 1);
    localparam logic [3:0]     FLUSH_INIT  = 4'(FLUSH_CYCLES);
    localparam logic [3:0]     LS_INIT     = 4'(LOAD_STALL_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_t     state_q;
    logic [3:0] rem;
    logic       mp;
    logic       lu;

    // Hazard decode: branch outcome disagrees with prediction, or EX load feeds ID.
    assign mp = ex_Branch & (ex_prediction != ex_taken);
    assign lu = ex_MemRead & (ex_rd != 5'd0) &
                ((ex_rd == id_rs1) | (id_uses_rs2 & (ex_rd == id_rs2)));

    assign state = state_q;

    // Sequencer: a freeze holds everything; a mispredict overrides any stall in progress.
    always_ff @(posedge clk) begin
        // NOTE: all registered state uses non-blocking assignment so every flop
        // samples the pre-edge values regardless of statement order.
        if (reset) begin
            state_q <= ST_RUN;
            rem     <= 4'd0;
        end else if (!mem_busy) begin
            if (mp) begin
                if (HAS_FLUSH) begin
                    state_q <= ST_FLUSH;
                    rem     <= FLUSH_INIT;
                end else begin
                    state_q <= ST_RUN;
                    rem     <= 4'd0;
                end
            end else begin
                case (state_q)
                    ST_FLUSH, ST_LOAD_STALL: begin
                        if (rem <= 4'd1) begin
                            state_q <= ST_RUN;
                            rem     <= 4'd0;
                        end else begin
                            rem <= rem - 4'd1;
                        end
                    end
                    ST_RUN: begin
                        if (lu && HAS_LS_TAIL) begin
                            state_q <= ST_LOAD_STALL;
                            rem     <= LS_INIT;
                        end
                    end
                    default: begin
                        state_q <= ST_RUN;
                        rem     <= 4'd0;
                    end
                endcase
            end
        end
    end

    // Control outputs: reset > mem_busy > mispredict > load-use/state sequencing.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves one
        // unassigned, which would otherwise infer a latch.
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        pc_redirect = 1'b0;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        stage_hold  = 1'b0;
        if (reset) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (mem_busy) begin
            stage_hold  = 1'b1;
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
        end else if (mp) begin
            pc_redirect = 1'b1;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (state_q == ST_FLUSH) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (state_q == ST_LOAD_STALL || (state_q == ST_RUN && lu)) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
        end
    end

    // Saturating performance counters; a frozen pipeline resolves no branches.
    always_ff @(posedge clk) begin
        if (reset) begin
            branch_cnt     <= '0;
            mispredict_cnt <= '0;
            stall_cnt      <= '0;
        end else begin
            if (ex_Branch && !mem_busy && branch_cnt != '1)
                branch_cnt <= branch_cnt + CNT_ONE;
            if (mp && !mem_busy && mispredict_cnt != '1)
                mispredict_cnt <= mispredict_cnt + CNT_ONE;
            if (!pc_write && stall_cnt != '1)
                stall_cnt <= stall_cnt + CNT_ONE;
        end
    end

endmodule
